// File: rtl/snn_input_loader.sv
// snn_input_loader: receives the packed binary input image byte by byte,
// unpacks it one pixel per cycle into a NUM_UNITS x 1 memory, pulses start
// to the core, and serves the core's single-bit reads until done re-arms it.
module snn_input_loader #(
  parameter int NUM_UNITS = 784,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W-1:0] addr_input_unit,
  output logic              d_input,
  input  logic              done,
  output logic              start,
  output logic              busy,
  output logic              overrun
);

  localparam logic [1:0] LOAD      = 2'd0;
  localparam logic [1:0] UNPACK    = 2'd1;
  localparam logic [1:0] KICK      = 2'd2;
  localparam logic [1:0] WAIT_CORE = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_UNITS - 1);
  localparam logic [ADDR_W:0]   UNITS_EXT = (ADDR_W + 1)'(NUM_UNITS);

  logic [1:0]        state;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;

  // Input-unit storage; intentionally not reset, contents valid after a full load.
  logic mem [NUM_UNITS];

  // Load/unpack/kick/wait sequencing, status flags and the start pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= LOAD;
      wr_addr <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      start   <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        LOAD: begin
          if (rx_rdy) begin
            shreg   <= rx_data;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= UNPACK;
          end
        end
        UNPACK: begin
          shreg   <= {1'b0, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (rx_rdy) begin
            overrun <= 1'b1;
          end
          // start is raised on entry so it is high for exactly the KICK cycle;
          // wr_addr holds at the last address instead of wrapping.
          if (bit_cnt == 3'd7 && wr_addr == LAST_ADDR) begin
            state <= KICK;
            start <= 1'b1;
          end else begin
            wr_addr <= wr_addr + ADDR_W'(1);
            if (bit_cnt == 3'd7) begin
              state <= LOAD;
            end
          end
        end
        KICK: begin
          wr_addr <= '0;
          state   <= WAIT_CORE;
          if (rx_rdy) begin
            overrun <= 1'b1;
          end
        end
        WAIT_CORE: begin
          if (rx_rdy) begin
            overrun <= 1'b1;
          end
          if (done) begin
            busy  <= 1'b0;
            state <= LOAD;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  // Pixel write: one bit per UNPACK cycle, LSB of the byte first.
  always_ff @(posedge clk) begin
    if (rst_n && state == UNPACK) begin
      mem[wr_addr] <= shreg[0];
    end
  end

  // Registered read port; out-of-range addresses return 0, read-before-write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_input <= 1'b0;
    end else if ({1'b0, addr_input_unit} < UNITS_EXT) begin
      d_input <= mem[addr_input_unit];
    end else begin
      d_input <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snn_input_loader.sv
// Directed self-checking bench for snn_input_loader with a read-data scoreboard.
module tb_snn_input_loader;

  localparam int NUM = 784;

  logic       clk;
  logic       rst_n;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic [9:0] addr_input_unit;
  logic       d_input;
  logic       done;
  logic       start;
  logic       busy;
  logic       overrun;

  int   total = 0;
  int   bad = 0;
  int   n_start = 0;
  logic exp_img [NUM];
  logic sb [$];

  snn_input_loader #(.NUM_UNITS(NUM), .ADDR_W(10)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_rdy(rx_rdy),
    .rx_data(rx_data),
    .addr_input_unit(addr_input_unit),
    .d_input(d_input),
    .done(done),
    .start(start),
    .busy(busy),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts start pulses seen at each active edge.
  always @(posedge clk) begin
    if (start === 1'b1) n_start <= n_start + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd(input int a, input logic e);
    logic got_exp;
    addr_input_unit = 10'(a);
    sb.push_back(e);
    tick();
    got_exp = sb.pop_front();
    chk($sformatf("rd@%0d", a), {31'd0, d_input}, {31'd0, got_exp});
  endtask

  task automatic sweep();
    for (int a = 0; a < NUM; a++) rd(a, exp_img[a]);
    rd(784, 1'b0);
    rd(1023, 1'b0);
    addr_input_unit = 10'd784;
  endtask

  // mode 0: byte k = k; mode 1: all 0xFF. Optional dropped byte and stray done.
  task automatic load_image(input int mode, input bit drop5, input bit stray_done);
    logic [7:0] b;
    int s0;
    s0 = n_start;
    for (int k = 0; k < 98; k++) begin
      b = (mode == 0) ? 8'(k) : 8'hFF;
      for (int i = 0; i < 8; i++) exp_img[8*k+i] = b[i];
      send_byte(b);
      if (k == 0) chk("busy_first_byte", {31'd0, busy}, 32'd1);
      if (k < 97) begin
        if (drop5 && k == 5) begin
          chk("overrun_pre", {31'd0, overrun}, 32'd0);
          idle(2);
          send_byte(8'h00);
          chk("overrun_unpack", {31'd0, overrun}, 32'd1);
          idle(16);
        end else if (stray_done && k == 20) begin
          idle(10);
          done = 1'b1;
          tick();
          done = 1'b0;
          chk("done_ignored_busy", {31'd0, busy}, 32'd1);
          idle(8);
        end else begin
          idle(19);
        end
        if (k == 96) chk("no_early_start", n_start, s0);
      end
    end
    idle(7);
    chk("start_t8", {31'd0, start}, 32'd0);
    tick();
    chk("start_t9", {31'd0, start}, 32'd1);
    chk("busy_at_start", {31'd0, busy}, 32'd1);
    tick();
    chk("start_one_cycle", {31'd0, start}, 32'd0);
    chk("start_once", n_start, s0 + 1);
  endtask

  initial begin
    int s1;
    rst_n = 1'b0;
    rx_rdy = 1'b0;
    rx_data = 8'h00;
    addr_input_unit = 10'd784;
    done = 1'b0;
    idle(2);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_d_input", {31'd0, d_input}, 32'd0);
    rst_n = 1'b1;
    idle(3);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_start_cnt", n_start, 0);

    // Image 1: byte k = k, one byte dropped during UNPACK.
    load_image(0, 1'b1, 1'b0);
    sweep();
    rd(9, 1'b0);
    rd(8, 1'b1);
    rd(783, 1'b0);
    addr_input_unit = 10'd784;

    // Re-arm, overrun stays sticky.
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("rearm_busy", {31'd0, busy}, 32'd0);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);

    // Partial load then reset: partial image discarded.
    s1 = n_start;
    for (int k = 0; k < 50; k++) begin
      send_byte(8'h00);
      idle(11);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_overrun", {31'd0, overrun}, 32'd0);
    chk("midrst_no_start", n_start, s1);

    // Image 2: all 0xFF, with a done pulse while loading.
    load_image(1, 1'b0, 1'b1);
    sweep();

    // Byte during WAIT_CORE is dropped and flags overrun.
    chk("wait_overrun_pre", {31'd0, overrun}, 32'd0);
    send_byte(8'h00);
    chk("wait_overrun", {31'd0, overrun}, 32'd1);
    chk("wait_busy", {31'd0, busy}, 32'd1);
    idle(10);
    rd(0, 1'b1);
    rd(7, 1'b1);
    addr_input_unit = 10'd784;

    // done and rx_rdy together: done wins.
    done = 1'b1;
    rx_data = 8'h00;
    rx_rdy = 1'b1;
    tick();
    done = 1'b0;
    rx_rdy = 1'b0;
    chk("done_rx_busy", {31'd0, busy}, 32'd0);
    idle(3);
    chk("done_rx_busy_hold", {31'd0, busy}, 32'd0);
    chk("done_rx_overrun", {31'd0, overrun}, 32'd1);
    rd(0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
